// File: rtl/eth_tx_pkg.sv
// Shared constants and FSM encoding for the ethernet_tx frame scheduler.
package eth_tx_pkg;

  localparam int FRAME_BYTES_DEF = 1350;
  localparam int PREFIX_NIBBLES  = 40;
  localparam int IFG_CYCLES_DEF  = 24;
  localparam int REQ_CNT_W       = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE      = 3'd1,
    ST_PRE_LAST = 3'd2,
    ST_DATA     = 3'd3,
    ST_GAP      = 3'd4
  } tx_state_e;

endpackage

// File: rtl/eth_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last source taken.
module eth_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_idx
);

  logic last;

  always_comb begin
    gnt_idx = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end
  end

  // Pointer starts at 1 so source 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (take) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/ethernet_tx_sched.sv
// Grants whole frames from two FWFT byte FIFOs to ethernet_tx, holds send_enale
// through the prefix, then enforces an inter-frame gap and tracks frame stats.
module ethernet_tx_sched
  import eth_tx_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int IFG_CYCLES  = IFG_CYCLES_DEF,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] fifo0_count,
  input  logic [7:0]       fifo0_dout,
  output logic             fifo0_rd_en,
  input  logic [CNT_W-1:0] fifo1_count,
  input  logic [7:0]       fifo1_dout,
  output logic             fifo1_rd_en,
  output logic [7:0]       tx_datain,
  input  logic             tx_data_request,
  input  logic             tx_ctrl,
  output logic             tx_send_enable,
  output logic             grant,
  output logic             busy,
  output logic [15:0]      frame_cnt0,
  output logic [15:0]      frame_cnt1,
  output logic             len_err,
  output logic [2:0]       dbg_state
);

  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     THRESH     = CNT_W'(FRAME_BYTES);
  localparam logic [REQ_CNT_W-1:0] REQ_TARGET = REQ_CNT_W'(FRAME_BYTES);
  localparam logic [REQ_CNT_W-1:0] REQ_ONE    = REQ_CNT_W'(1);
  localparam logic [GAP_W-1:0]     GAP_LOAD   = GAP_W'(IFG_CYCLES - 1);
  localparam logic [GAP_W-1:0]     GAP_ONE    = GAP_W'(1);

  tx_state_e            state, state_nxt;
  logic [1:0]           req;
  logic                 gnt_idx;
  logic                 take;
  logic                 in_frame;
  logic                 frame_end;
  logic [REQ_CNT_W-1:0] req_cnt;
  logic [GAP_W-1:0]     gap_cnt;

  assign req[0]    = (fifo0_count >= THRESH);
  assign req[1]    = (fifo1_count >= THRESH);
  assign take      = (state == ST_IDLE) && enable && (req != 2'b00);
  assign in_frame  = (state == ST_PRE) || (state == ST_PRE_LAST) || (state == ST_DATA);
  assign frame_end = (state == ST_DATA) && !tx_ctrl;
  assign dbg_state = state;

  eth_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .take    (take),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The transmitter samples send_enale once more after its first request, so
  // PRE_LAST keeps it high for that extra clock.
  always_comb begin
    state_nxt      = state;
    tx_send_enable = 1'b0;
    busy           = (state != ST_IDLE);
    case (state)
      ST_IDLE:     if (take) state_nxt = ST_PRE;
      ST_PRE: begin
        tx_send_enable = 1'b1;
        if (tx_data_request) state_nxt = ST_PRE_LAST;
      end
      ST_PRE_LAST: begin
        tx_send_enable = 1'b1;
        state_nxt      = ST_DATA;
      end
      ST_DATA:     if (!tx_ctrl) state_nxt = ST_GAP;
      ST_GAP:      if (gap_cnt == '0) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Handshake: tx_data_request acts as ready, FWFT dout as valid data; a pop
  // happens in the very clock the transmitter requests, with no added latency.
  always_comb begin
    fifo0_rd_en = 1'b0;
    fifo1_rd_en = 1'b0;
    tx_datain   = 8'h00;
    if (in_frame) begin
      if (grant) begin
        tx_datain   = fifo1_dout;
        fifo1_rd_en = tx_data_request;
      end else begin
        tx_datain   = fifo0_dout;
        fifo0_rd_en = tx_data_request;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= 1'b0;
      req_cnt    <= '0;
      gap_cnt    <= '0;
      frame_cnt0 <= 16'd0;
      frame_cnt1 <= 16'd0;
      len_err    <= 1'b0;
    end else begin
      if (take) begin
        grant   <= gnt_idx;
        req_cnt <= '0;
      end else if (in_frame && tx_data_request && (req_cnt != '1)) begin
        req_cnt <= req_cnt + REQ_ONE;
      end

      if (frame_end) begin
        gap_cnt <= GAP_LOAD;
        if (grant) frame_cnt1 <= frame_cnt1 + 16'd1;
        else       frame_cnt0 <= frame_cnt0 + 16'd1;
        if (req_cnt != REQ_TARGET) len_err <= 1'b1;
      end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GAP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ethernet_tx_sched.sv
// Directed bench for ethernet_tx_sched with a behavioural transmitter and an
// event-level scheduler model compared against the DUT every clock.
module tb_ethernet_tx_sched;
  import eth_tx_pkg::*;

  localparam int FB  = 1350;
  localparam int IFG = 24;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] fifo0_count = '0;
  logic [7:0]  fifo0_dout = '0;
  logic        fifo0_rd_en;
  logic [11:0] fifo1_count = '0;
  logic [7:0]  fifo1_dout = '0;
  logic        fifo1_rd_en;
  logic [7:0]  tx_datain;
  logic        tx_data_request = 1'b0;
  logic        tx_ctrl = 1'b0;
  logic        tx_send_enable;
  logic        grant;
  logic        busy;
  logic [15:0] frame_cnt0;
  logic [15:0] frame_cnt1;
  logic        len_err;
  logic [2:0]  dbg_state;

  always #20 clk = ~clk;

  ethernet_tx_sched dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .fifo0_count     (fifo0_count),
    .fifo0_dout      (fifo0_dout),
    .fifo0_rd_en     (fifo0_rd_en),
    .fifo1_count     (fifo1_count),
    .fifo1_dout      (fifo1_dout),
    .fifo1_rd_en     (fifo1_rd_en),
    .tx_datain       (tx_datain),
    .tx_data_request (tx_data_request),
    .tx_ctrl         (tx_ctrl),
    .tx_send_enable  (tx_send_enable),
    .grant           (grant),
    .busy            (busy),
    .frame_cnt0      (frame_cnt0),
    .frame_cnt1      (frame_cnt1),
    .len_err         (len_err),
    .dbg_state       (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // stimulus knobs, applied to the DUT inside step()
  logic        rst_v = 1'b1;
  logic        en_v  = 1'b0;
  logic [11:0] cnt0_v = '0;
  logic [11:0] cnt1_v = '0;
  int          tx_nreq = FB;

  // behavioural transmitter: tx_k counts clocks since send_enale first seen
  int   tx_k = 0;
  logic se_prev = 1'b0;
  int   pops0 = 0;
  int   pops1 = 0;

  // observations for literal checks
  logic se_last = 1'b0;
  int   se_run = 0;
  int   last_se_len = 0;
  int   rd0_pulses = 0;
  int   rd1_pulses = 0;
  int   gap_run = 0;
  int   grant_q[$];
  int   gap_q[$];

  // event-level scheduler model
  logic        m_open = 1'b0;
  int          m_first_req = -1;
  int          m_req = 0;
  int          m_gap = 0;
  int          m_frames = 0;
  logic        m_grant = 1'b0;
  logic        m_last = 1'b1;
  logic        m_len_err = 1'b0;
  logic [15:0] m_cnt0 = '0;
  logic [15:0] m_cnt1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver + scoreboard, one clock ----------------
  task automatic step();
    int   kend;
    logic e_se, e_rd0, e_rd1, pick;
    logic [7:0] e_dat;
    @(posedge clk);
    #1;
    kend = 41 + 2 * (tx_nreq - 2) + 2;
    if (tx_k != 0 && tx_k == kend) tx_k = 0;
    else if (tx_k != 0)           tx_k++;
    else if (se_prev)             tx_k = 1;
    tx_data_request = (tx_k == 39) ||
                      (tx_k >= 41 && tx_k <= kend - 2 && ((tx_k - 41) % 2) == 0);
    tx_ctrl     = (tx_k >= 1) && (tx_k < kend);
    rst         = rst_v;
    enable      = en_v;
    fifo0_count = cnt0_v;
    fifo1_count = cnt1_v;
    fifo0_dout  = 8'((pops0 * 7) + 3);
    fifo1_dout  = 8'((pops1 * 5) + 200);
    #1;

    e_se  = m_open && (m_first_req < 0 || m_first_req == cyc - 1);
    e_rd0 = m_open && !m_grant && tx_data_request;
    e_rd1 = m_open && m_grant && tx_data_request;
    e_dat = !m_open ? 8'h00 : (m_grant ? fifo1_dout : fifo0_dout);
    chk("send_enable", tx_send_enable, e_se);
    chk("busy", busy, m_open || (m_gap > 0));
    chk("grant", grant, m_grant);
    chk("fifo0_rd_en", fifo0_rd_en, e_rd0);
    chk("fifo1_rd_en", fifo1_rd_en, e_rd1);
    chk("tx_datain", tx_datain, e_dat);
    chk("frame_cnt0", frame_cnt0, m_cnt0);
    chk("frame_cnt1", frame_cnt1, m_cnt1);
    chk("len_err", len_err, m_len_err);

    // observations
    if (tx_send_enable && !se_last) begin
      grant_q.push_back(int'(grant));
      se_run = 0;
    end
    if (tx_send_enable) se_run++;
    if (!tx_send_enable && se_last) last_se_len = se_run;
    se_last = tx_send_enable;
    if (dbg_state == ST_GAP) gap_run++;
    else if (gap_run > 0) begin
      gap_q.push_back(gap_run);
      gap_run = 0;
    end
    if (fifo0_rd_en) begin pops0++; rd0_pulses++; end
    if (fifo1_rd_en) begin pops1++; rd1_pulses++; end
    se_prev = tx_send_enable;
    if (rst) begin
      tx_k    = 0;
      se_prev = 1'b0;
    end

    // model advances across this clock edge
    if (rst) begin
      m_open = 1'b0; m_first_req = -1; m_req = 0; m_gap = 0;
      m_grant = 1'b0; m_last = 1'b1; m_len_err = 1'b0;
      m_cnt0 = '0; m_cnt1 = '0;
    end else if (m_open) begin
      if (m_first_req >= 0 && cyc >= m_first_req + 2 && !tx_ctrl) begin
        if (m_grant) m_cnt1 = m_cnt1 + 16'd1;
        else         m_cnt0 = m_cnt0 + 16'd1;
        if (m_req != FB) m_len_err = 1'b1;
        m_open = 1'b0;
        m_gap  = IFG;
        m_frames++;
      end else if (tx_data_request) begin
        m_req++;
        if (m_first_req < 0) m_first_req = cyc;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (enable && (fifo0_count >= FB || fifo1_count >= FB)) begin
      if (fifo0_count >= FB && fifo1_count >= FB) pick = ~m_last;
      else pick = (fifo1_count >= FB);
      m_grant = pick; m_last = pick;
      m_open = 1'b1; m_req = 0; m_first_req = -1;
    end
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_frames(input int n, input int budget);
    int target;
    int t;
    target = m_frames + n;
    t = 0;
    while (m_frames < target && t < budget) begin
      step();
      t++;
    end
    chk("frame_timeout", m_frames, target);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int g0;
    int t;
    int q_exp[4];

    rst_v = 1'b1;
    steps(2);
    rst_v = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_grant", grant, 0);
    chk("reset_cnt0", frame_cnt0, 0);
    steps(2);

    // round robin: both eligible for four frames
    en_v = 1'b1; cnt0_v = 12'd2000; cnt1_v = 12'd2000;
    run_frames(4, 12000);
    cnt0_v = '0; cnt1_v = '0;
    steps(30);
    q_exp = '{0, 1, 0, 1};
    chk("rr_grant_count", grant_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_q.size()) chk("rr_grant_seq", grant_q[i], q_exp[i]);
      if (i < gap_q.size())   chk("rr_gap_len", gap_q[i], 24);
    end
    chk("rr_gap_count", gap_q.size(), 4);
    chk("rr_cnt0", frame_cnt0, 2);
    chk("rr_cnt1", frame_cnt1, 2);

    // single grant, source 0 only
    rd0_pulses = 0; rd1_pulses = 0;
    cnt0_v = 12'd1350;
    run_frames(1, 3000);
    cnt0_v = '0;
    steps(30);
    chk("single_se_len", last_se_len, 41);
    chk("single_rd0", rd0_pulses, 1350);
    chk("single_rd1", rd1_pulses, 0);
    chk("single_cnt0", frame_cnt0, 3);
    chk("single_len_err", len_err, 0);

    // threshold
    cnt0_v = 12'd1349;
    g0 = grant_q.size();
    steps(60);
    chk("thresh_no_grant", grant_q.size(), g0);
    chk("thresh_idle", busy, 0);
    cnt0_v = 12'd1350;
    step();
    chk("thresh_se_n", tx_send_enable, 0);
    step();
    chk("thresh_se_n1", tx_send_enable, 1);
    run_frames(1, 3000);
    cnt0_v = '0;
    steps(30);
    chk("thresh_cnt0", frame_cnt0, 4);

    // enable drop at data byte 500
    rd0_pulses = 0;
    cnt0_v = 12'd1350;
    t = 0;
    while (rd0_pulses < 500 && t < 3000) begin step(); t++; end
    chk("drop_reach_500", rd0_pulses, 500);
    en_v = 1'b0;
    run_frames(1, 3000);
    g0 = grant_q.size();
    steps(60);
    chk("drop_cnt0", frame_cnt0, 5);
    chk("drop_rd0", rd0_pulses, 1350);
    chk("drop_no_grant", grant_q.size(), g0);
    chk("drop_idle", busy, 0);
    cnt0_v = '0;

    // length error: transmitter ends after 1000 requests
    en_v = 1'b1; cnt1_v = 12'd1350; tx_nreq = 1000;
    run_frames(1, 3000);
    cnt1_v = '0;
    steps(30);
    chk("lenerr_set", len_err, 1);
    chk("lenerr_cnt1", frame_cnt1, 3);
    tx_nreq = FB;
    cnt0_v = 12'd1350;
    run_frames(1, 3000);
    cnt0_v = '0;
    steps(30);
    chk("lenerr_sticky", len_err, 1);
    chk("lenerr_cnt0", frame_cnt0, 6);

    // reset mid-prefix
    cnt0_v = 12'd1350;
    t = 0;
    while (tx_k != 20 && t < 200) begin step(); t++; end
    chk("rst_reach_nibble", tx_k, 20);
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
    step();
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_se", tx_send_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_rd", {fifo0_rd_en, fifo1_rd_en}, 0);
    chk("rst_datain", tx_datain, 0);
    chk("rst_cnt0", frame_cnt0, 0);
    chk("rst_cnt1", frame_cnt1, 0);
    chk("rst_len_err", len_err, 0);
    rd0_pulses = 0;
    run_frames(1, 3000);
    cnt0_v = '0;
    steps(30);
    chk("rst_new_cnt0", frame_cnt0, 1);
    chk("rst_new_rd0", rd0_pulses, 1350);
    chk("rst_new_len_err", len_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
